// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared FSM state encoding, byte width and parity helper for
//               the SRAM arbiter/controller slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Even parity: the stored bit makes byte+parity carry an even number of ones.
    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_array.sv
// ============================================================================
// Module      : sram_array
// Description : Single-port synchronous SRAM, byte-enabled write, registered
//               read, optional per-byte even-parity storage (PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_array
    import sram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/BYTE_W-1:0] be,
    output logic [DATA_W-1:0]        rdata,
    output logic                     parity_err
);

    localparam int NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the controller's INIT sweep defines them.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

    generate
        if (PARITY_EN) begin : g_parity
            logic [NB-1:0] par_mem [DEPTH];
            logic [NB-1:0] par_q;
            logic [NB-1:0] mismatch;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        for (int b = 0; b < NB; b++) begin
                            if (be[b]) begin
                                par_mem[addr][b] <= even_parity(wdata[b*BYTE_W +: BYTE_W]);
                            end
                        end
                    end else begin
                        par_q <= par_mem[addr];
                    end
                end
            end

            always_comb begin
                mismatch = '0;
                for (int b = 0; b < NB; b++) begin
                    mismatch[b] = even_parity(rdata[b*BYTE_W +: BYTE_W]) ^ par_q[b];
                end
            end

            assign parity_err = |mismatch;
        end else begin : g_no_parity
            assign parity_err = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sram_arb_ctrl.sv
// ============================================================================
// Module      : sram_arb_ctrl
// Description : Round-robin multi-channel SRAM controller with zeroing INIT
//               sweep and 1-cycle response path. Define SRAM_ARB_CTRL_PARITY_EN
//               to add per-byte parity storage and read checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int NUM_CH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic [NUM_CH-1:0]               req_valid,
    output logic [NUM_CH-1:0]               req_ready,
    input  logic [NUM_CH-1:0]               req_write,
    input  logic [NUM_CH*ADDR_W-1:0]        req_addr,
    input  logic [NUM_CH*DATA_W-1:0]        req_wdata,
    input  logic [NUM_CH*DATA_W/BYTE_W-1:0] req_be,
    output logic [NUM_CH-1:0]               rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            rsp_err,
    output logic                            init_busy
);

    localparam int BE_W  = DATA_W / BYTE_W;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef SRAM_ARB_CTRL_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    state_t              state;
    logic [ADDR_W-1:0]   init_cnt;
    logic [PTR_W-1:0]    ptr;
    logic                rsp_read;
    logic                rsp_oor;

    logic [NUM_CH-1:0]   grant;
    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W-1:0]    nxt_ptr;
    logic                xfer;

    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;
    logic                sel_oor;

    logic                ram_en;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [BE_W-1:0]     ram_be;
    logic [DATA_W-1:0]   ram_rdata;
    logic                ram_perr;

    // Search from the priority pointer upward, wrapping, and take the first valid channel.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        grant   = '0;
        gnt_idx = '0;
        xfer    = 1'b0;
        idx     = 0;
        cand    = '0;
        if (state == READY && !clear) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                cand = PTR_W'(idx);
                if (!xfer && req_valid[cand]) begin
                    xfer        = 1'b1;
                    grant[cand] = 1'b1;
                    gnt_idx     = cand;
                end
            end
        end
    end

    assign nxt_ptr   = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);

    assign sel_write = req_write[gnt_idx];
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_be    = req_be[int'(gnt_idx)*BE_W +: BE_W];
    assign sel_oor   = 32'(sel_addr) >= 32'(DEPTH);

    // INIT owns the RAM port; no grants are issued there, so there is no contention.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = sel_addr;
        ram_wdata = sel_wdata;
        ram_be    = sel_be;
        if (state == INIT) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = init_cnt;
            ram_wdata = '0;
            ram_be    = '1;
        end else if (xfer && !sel_oor) begin
            ram_en    = 1'b1;
            ram_we    = sel_write;
        end
    end

    sram_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .PARITY_EN (PARITY_EN)
    ) u_array (
        .clk        (clk),
        .en         (ram_en),
        .we         (ram_we),
        .addr       (ram_addr),
        .wdata      (ram_wdata),
        .be         (ram_be),
        .rdata      (ram_rdata),
        .parity_err (ram_perr)
    );

    // Response registers update regardless of state so a transfer just before clear still answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_read  <= 1'b0;
            rsp_oor   <= 1'b0;
        end else begin
            rsp_valid <= grant;
            rsp_read  <= xfer && !sel_write && !sel_oor;
            rsp_oor   <= xfer && sel_oor;
            case (state)
                INIT: begin
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state    <= READY;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + ADDR_W'(1);
                    end
                end
                READY: begin
                    if (clear) begin
                        state    <= INIT;
                        init_cnt <= '0;
                    end else if (xfer) begin
                        ptr <= nxt_ptr;
                    end
                end
                default: begin
                    state    <= INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    assign req_ready = grant;
    assign init_busy = (state == INIT);
    assign rsp_rdata = rsp_read ? ram_rdata : '0;
    assign rsp_err   = rsp_oor || (rsp_read && ram_perr);

endmodule

`default_nettype wire
